// File: rtl/min_sec_counter_pkg.sv
// Shared timer constants and BCD helpers for the PengTimer clock chain
// (seconds/minutes stage, hour stage and display).
package min_sec_counter_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;
    localparam logic [DIGIT_W-1:0] UNITS_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] tens,
                                       input logic [DIGIT_W-1:0] units);
        return (tens <= TENS_MAX) && (units <= UNITS_MAX);
    endfunction

endpackage

// File: rtl/min_sec_counter_bcd_mod60.sv
// Two-digit BCD modulo-60 counter with synchronous load; carry flags the
// 59 -> 00 wrap in the same cycle the increment is requested.
module bcd_mod60
    import min_sec_counter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_tens,
    input  logic [DIGIT_W-1:0] load_units,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units,
    output logic               carry
);

    assign carry = inc && !load && (tens == TENS_MAX) && (units == UNITS_MAX);

    // Load takes priority; the top only presents in-range load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens  <= '0;
            units <= '0;
        end else if (load) begin
            tens  <= load_tens;
            units <= load_units;
        end else if (inc) begin
            if (units == UNITS_MAX) begin
                units <= '0;
                tens  <= (tens == TENS_MAX) ? '0 : tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/min_sec_counter.sv
// Minutes/seconds stage: 1 Hz prescaler, BCD seconds and minutes, manual
// minute load and a one-cycle hour carry on the 59:59 -> 00:00 rollover.
module min_sec_counter
    import min_sec_counter_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               set_min,
    input  logic               set_hour,
    input  logic [DIGIT_W-1:0] set_num1,
    input  logic [DIGIT_W-1:0] set_num2,
    output logic               sec_tick,
    output logic [DIGIT_W-1:0] out_s1,
    output logic [DIGIT_W-1:0] out_s2,
    output logic [DIGIT_W-1:0] out_m1,
    output logic [DIGIT_W-1:0] out_m2,
    output logic               hour_inc
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] presc;
    logic               frozen;
    logic               terminal;
    logic               load_ok;
    logic               sec_carry;
    logic               min_carry;

    assign frozen   = ~en | set_min | set_hour;
    assign terminal = ~frozen && (presc == PRESC_LAST);
    // An out-of-range digit pair is dropped so the outputs stay valid BCD.
    assign load_ok  = set_min && bcd_valid(set_num1, set_num2);

    // Freezing clears the prescaler so a resume always starts a full second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (frozen || terminal) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_tick <= 1'b0;
            hour_inc <= 1'b0;
        end else begin
            sec_tick <= terminal;
            hour_inc <= min_carry;
        end
    end

    bcd_mod60 u_seconds (
        .clk        (clk),
        .rst        (rst),
        .inc        (terminal),
        .load       (load_ok),
        .load_tens  ('0),
        .load_units ('0),
        .tens       (out_s1),
        .units      (out_s2),
        .carry      (sec_carry)
    );

    bcd_mod60 u_minutes (
        .clk        (clk),
        .rst        (rst),
        .inc        (sec_carry),
        .load       (load_ok),
        .load_tens  (set_num1),
        .load_units (set_num2),
        .tens       (out_m1),
        .units      (out_m2),
        .carry      (min_carry)
    );

endmodule

// File: tb/tb_min_sec_counter.sv
// Bench for min_sec_counter (CLK_HZ=4): directed scenarios plus random
// stimulus against a seconds-of-hour reference model.
module tb_min_sec_counter;

    localparam int HZ = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       set_min = 1'b0;
    logic       set_hour = 1'b0;
    logic [3:0] set_num1 = 4'd0;
    logic [3:0] set_num2 = 4'd0;
    logic       sec_tick;
    logic       hour_inc;
    logic [3:0] out_s1, out_s2, out_m1, out_m2;
    logic [15:0] dig;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int hinc_cnt = 0;

    // Reference model: position within the hour in whole seconds, plus the
    // number of enabled cycles already spent in the current second.
    int   m_phase = 0;
    int   m_total = 0;
    logic m_tick = 1'b0;
    logic m_hinc = 1'b0;

    min_sec_counter #(.CLK_HZ(HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .set_min  (set_min),
        .set_hour (set_hour),
        .set_num1 (set_num1),
        .set_num2 (set_num2),
        .sec_tick (sec_tick),
        .out_s1   (out_s1),
        .out_s2   (out_s2),
        .out_m1   (out_m1),
        .out_m2   (out_m2),
        .hour_inc (hour_inc)
    );

    assign dig = {out_m1, out_m2, out_s1, out_s2};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_total = 0;
        m_tick  = 1'b0;
        m_hinc  = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            m_tick = 1'b0;
            m_hinc = 1'b0;
            if (!en || set_min || set_hour) begin
                m_phase = 0;
                if (set_min && set_num1 <= 4'd5 && set_num2 <= 4'd9)
                    m_total = (int'(set_num1) * 10 + int'(set_num2)) * 60;
            end else if (m_phase == HZ - 1) begin
                m_phase = 0;
                m_tick  = 1'b1;
                m_total = (m_total + 1) % 3600;
                m_hinc  = (m_total == 0);
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sec_tick", 32'(sec_tick), 32'(m_tick));
        check("hour_inc", 32'(hour_inc), 32'(m_hinc));
        check("digits", 32'(dig), 32'(pack(m_total)));
        tick_cnt += int'(sec_tick);
        hinc_cnt += int'(hour_inc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [3:0] n1, input logic [3:0] n2);
        set_min  = 1'b1;
        set_num1 = n1;
        set_num2 = n2;
        step();
        set_min  = 1'b0;
    endtask

    initial begin
        int wait_cycles;

        // Reset state
        #1;
        check("reset_digits", 32'(dig), 32'h0);
        check("reset_pulses", 32'({sec_tick, hour_inc}), 32'h0);
        run(2);
        rst = 1'b0;
        run(10);

        // Asynchronous reset mid-count clears outputs without a clock edge
        #2 rst = 1'b1;
        #1;
        check("async_rst_digits", 32'(dig), 32'h0);
        check("async_rst_pulses", 32'({sec_tick, hour_inc}), 32'h0);
        model_reset();
        run(2);
        rst = 1'b0;
        wait_cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (sec_tick) begin
                wait_cycles = i;
                break;
            end
        end
        check("first_tick_latency", 32'(wait_cycles), 32'd4);

        // Count one minute from 00:00
        load(4'd0, 4'd0);
        tick_cnt = 0;
        hinc_cnt = 0;
        run(240);
        check("count_ticks", 32'(tick_cnt), 32'd60);
        check("count_digits", 32'(dig), 32'h0100);
        check("count_no_hinc", 32'(hinc_cnt), 32'd0);

        // Rollover 59:00 -> 00:00
        load(4'd5, 4'd9);
        tick_cnt = 0;
        hinc_cnt = 0;
        run(240);
        check("roll_digits", 32'(dig), 32'h0000);
        check("roll_hinc_now", 32'(hour_inc), 32'd1);
        run(4);
        check("roll_hinc_count", 32'(hinc_cnt), 32'd1);

        // Manual set while counting
        load(4'd1, 4'd2);
        run(180);
        check("set_pre_digits", 32'(dig), 32'h1245);
        set_min = 1'b1; set_num1 = 4'd3; set_num2 = 4'd7;
        tick_cnt = 0;
        run(10);
        check("set_digits", 32'(dig), 32'h3700);
        check("set_no_ticks", 32'(tick_cnt), 32'd0);
        set_num1 = 4'd6; set_num2 = 4'd0;
        run(5);
        check("set_invalid_hold", 32'(dig), 32'h3700);
        set_min = 1'b0;

        // Freeze via set_hour, then via en
        load(4'd0, 4'd0);
        run(232);
        check("freeze_pre", 32'(dig), 32'h0058);
        set_hour = 1'b1;
        tick_cnt = 0;
        hinc_cnt = 0;
        run(20);
        check("freeze_hold", 32'(dig), 32'h0058);
        check("freeze_no_pulses", 32'(tick_cnt + hinc_cnt), 32'd0);
        set_hour = 1'b0;
        run(4);
        check("freeze_resume", 32'(dig), 32'h0059);
        en = 1'b0;
        tick_cnt = 0;
        run(20);
        check("pause_hold", 32'(dig), 32'h0059);
        check("pause_no_ticks", 32'(tick_cnt), 32'd0);
        en = 1'b1;
        run(4);
        check("pause_resume", 32'(dig), 32'h0100);

        // set_min and set_hour together on the 59:59 terminal cycle
        load(4'd5, 4'd9);
        run(239);
        check("simul_pre", 32'(dig), 32'h5959);
        set_min = 1'b1; set_hour = 1'b1; set_num1 = 4'd1; set_num2 = 4'd2;
        hinc_cnt = 0;
        step();
        check("simul_digits", 32'(dig), 32'h1200);
        set_min = 1'b0; set_hour = 1'b0;
        run(8);
        check("simul_no_hinc", 32'(hinc_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            en       = ($urandom_range(0, 9) != 0);
            set_min  = ($urandom_range(0, 24) == 0);
            set_hour = ($urandom_range(0, 39) == 0);
            set_num1 = 4'($urandom_range(0, 7));
            set_num2 = 4'($urandom_range(0, 11));
            step();
        end
        rst = 1'b0; en = 1'b1; set_min = 1'b0; set_hour = 1'b0;
        run(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
